i8253_counter: RTL and testbench
================================

// Module: i8253_counter
// PURPOSE
// - One 16-bit counter channel of an Intel 8253-compatible programmable interval timer.
// - The parent register/bus block decodes the control word into one-hot mode flags and byte-write strobes.
// - This block holds the count register (CR), the counting element (CE) and the OUT logic.
// - Modes 0-5 and binary/BCD counting are supported.
// PARAMETERS
// - none
// PORTS
// - clk           in   1   system clock; single clock domain, all state on posedge clk
// - reset         in   1   asynchronous, active-high reset
// - clk0_en       in   1   one-clk pulse; clk0 toggles on the same posedge clk
// - clk0          in   1   counter clock level, synchronous to clk
// - gate0         in   1   GATE input level
// - out0          out  1   OUT pin level, registered
// - load_counter  in   8   byte written to CR
// - counter0      out  16  current CE value, for readback
// - wr_cw         in   1   control word written; mode0..5/bcd valid
// - wr_lsb        in   1   write load_counter to CR[7:0]
// - wr_msb        in   1   write load_counter to CR[15:8]
// - wr_trigger    in   1   count write complete (last byte of the access sequence)
// - mode0..mode5  in   1   one-hot mode select; if several are set, lowest index wins
// - bcd           in   1   1 = 4-decade BCD count, 0 = 16-bit binary count
// BEHAVIOUR
// - Reset: CR=0, CE=0, out0=0, counter0=0, no load pending, counting stopped.
// - Event definitions:
//   - count edge (CE) = clk0_en & clk0 (clk0 falling).
//   - rise edge (RE) = clk0_en & ~clk0 (clk0 rising).
//   - gate0 is sampled at RE; "gate trigger" = sampled 0->1.
// - Strobes may be held high for many clk cycles.
//   - wr_lsb/wr_msb are level writes; rewriting is idempotent.
//   - wr_trigger and wr_cw act on their rising edge only (internal delayed copies).
// - wr_cw: stops counting, cancels any pending load, latches mode/bcd.
//   - out0 goes to 0 in mode0 and to 1 in modes 1-5.
//   - If wr_cw and wr_lsb/msb are asserted in the same cycle, wr_cw is applied first.
// - wr_trigger: sets load_pending.
//   - Modes 0, 2, 3, 4: CR->CE at the next CE; counting starts there.
//   - Modes 1, 5: only arms; the load waits for a gate trigger.
// - Decrement: binary wraps 0000->FFFF. BCD decrements per decade, 0000->9999. CR=0 means 65536 (binary) or 10000 (BCD).
// - Mode 0 (interrupt on terminal count):
//   - out0=0 after load; CE decrements on each CE while gate0=1 and holds while gate0=0.
//   - out0 goes 1 when CE reaches 0; CE keeps wrapping and out0 stays 1.
//   - A new wr_trigger drops out0 to 0 and reloads.
// - Mode 1 (retriggerable one-shot):
//   - A gate trigger reloads CE at the next CE and drives out0=0.
//   - out0 goes 1 at CE=0; a retrigger mid-count reloads and out0 stays 0.
// - Mode 2 (rate generator):
//   - out0 goes 0 for exactly one clk0 period while CE=1; at the next CE, CE reloads from CR and out0 goes 1.
//   - gate0=0 forces out0=1 and halts counting; a gate trigger reloads.
// - Mode 3 (square wave):
//   - CE decrements by 2. Even N: out0 is high N/2 and low N/2 periods.
//   - Odd N: high (N+1)/2, low (N-1)/2 periods.
//   - gate0=0 forces out0=1 and halts; a gate trigger reloads.
// - Mode 4 (software strobe): counts as mode 0 gating, but out0 stays 1 and pulses 0 for one clk0 period when CE reaches 0.
// - Mode 5 (hardware strobe): as mode 4 output, but started and restarted by a gate trigger.
// - A new count written mid-operation takes effect at the next reload point in modes 2/3, and immediately in modes 0/4.
// - counter0 always reflects CE, with zero additional latency.
// CONFIGURATION
// - I8253_COUNTER_BCD_EN defined: bcd input honoured (BCD decrement/wrap as above).
// - I8253_COUNTER_BCD_EN undefined: bcd ignored; binary counting only; BCD adder logic removed.
// TESTING
// - Reset 10 clk, release -> counter0=16'h0000, out0=0.
// - mode0, gate0=1, CR=0x0004 + wr_trigger -> out0=0, CE counts 4,3,2,1,0; out0=1 at CE=0 and stays 1.
// - Same, with gate0=0 for 4 clk0 periods mid-count -> CE frozen; out0 rise delayed by 4 periods.
// - mode1, CR=4, gate0 pulse -> out0 low exactly 4 clk0 periods.
//   - Second pulse 20 periods later -> another 4-period low.
// - mode2, CR=4, gate0=1 -> out0 low 1 of every 4 periods.
//   - Rewrite CR=20 -> period becomes 20 after the current cycle.
// - mode3, CR=5 -> out0 high 3, low 2 periods, repeating.
//   - gate0=0 for 3 periods -> out0=1; restarts on the gate rise.
// - mode4 CR=40 / mode5 CR=4 + gate rise -> single one-period low pulse at terminal count.

Source files
------------

// File: rtl/i8253_counter.sv
// i8253_counter: one 16-bit channel of an 8253-style interval timer (CR, CE, OUT, modes 0-5).
// Define I8253_COUNTER_BCD_EN to honour the bcd input; otherwise counting is binary only.

module i8253_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk0_en,
    input  logic        clk0,
    input  logic        gate0,
    output logic        out0,
    input  logic [7:0]  load_counter,
    output logic [15:0] counter0,
    input  logic        wr_cw,
    input  logic        wr_lsb,
    input  logic        wr_msb,
    input  logic        wr_trigger,
    input  logic        mode0,
    input  logic        mode1,
    input  logic        mode2,
    input  logic        mode3,
    input  logic        mode4,
    input  logic        mode5,
    input  logic        bcd
);

    typedef enum logic [2:0] {
        MODE_0 = 3'd0,
        MODE_1 = 3'd1,
        MODE_2 = 3'd2,
        MODE_3 = 3'd3,
        MODE_4 = 3'd4,
        MODE_5 = 3'd5
    } mode_e;

    mode_e       mode_q;
    mode_e       mode_d;
    mode_e       mode_sel;

    logic [15:0] cr_q;
    logic [15:0] cr_d;
    logic [15:0] ce_q;
    logic [15:0] ce_d;
    logic        out_q;
    logic        out_d;
    logic        load_q;
    logic        load_d;
    logic        run_q;
    logic        run_d;
    logic        armed_q;
    logic        armed_d;
    logic        started_q;
    logic        started_d;
    logic        gtrig_q;
    logic        gtrig_d;
    logic        gate_q;
    logic        gate_d;
    logic        hold_q;
    logic        hold_d;
    logic        trig_dly_q;
    logic        cw_dly_q;

    logic        cnt_edge;
    logic        rise_edge;
    logic        trig_rise;
    logic        cw_rise;
    logic [15:0] dec1;
    logic [15:0] dec2;
    logic [15:0] cr_even;

`ifdef I8253_COUNTER_BCD_EN
    logic        bcd_q;
    logic        bcd_d;

    // Four-decade BCD decrement: 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    logic        unused_bcd;
    assign unused_bcd = bcd;
`endif

    assign out0     = out_q;
    assign counter0 = ce_q;

    // Clock-edge and strobe-edge events for this clk cycle.
    always_comb begin
        cnt_edge  = clk0_en & clk0;
        rise_edge = clk0_en & ~clk0;
        trig_rise = wr_trigger & ~trig_dly_q;
        cw_rise   = wr_cw & ~cw_dly_q;
    end

    // One-hot mode flags to an encoded mode; lowest index wins.
    always_comb begin
        mode_sel = MODE_0;
        priority case (1'b1)
            mode0:   mode_sel = MODE_0;
            mode1:   mode_sel = MODE_1;
            mode2:   mode_sel = MODE_2;
            mode3:   mode_sel = MODE_3;
            mode4:   mode_sel = MODE_4;
            mode5:   mode_sel = MODE_5;
            default: mode_sel = MODE_0;
        endcase
    end

    // Decrement-by-one and by-two of CE, plus CR rounded down to even.
    always_comb begin
`ifdef I8253_COUNTER_BCD_EN
        dec1 = bcd_q ? bcd_dec(ce_q) : ce_q - 16'd1;
        dec2 = bcd_q ? bcd_dec(bcd_dec(ce_q)) : ce_q - 16'd2;
`else
        dec1 = ce_q - 16'd1;
        dec2 = ce_q - 16'd2;
`endif
        cr_even = {cr_q[15:1], 1'b0};
    end

    // Next-state: count edge, then gate sampling, then trigger, then control word.
    always_comb begin
        mode_d    = mode_q;
        cr_d      = cr_q;
        ce_d      = ce_q;
        out_d     = out_q;
        load_d    = load_q;
        run_d     = run_q;
        armed_d   = armed_q;
        started_d = started_q;
        gtrig_d   = gtrig_q;
        gate_d    = gate_q;
        hold_d    = hold_q;
`ifdef I8253_COUNTER_BCD_EN
        bcd_d     = bcd_q;
`endif

        if (cnt_edge) begin
            gtrig_d = 1'b0;
            unique case (mode_q)
                MODE_0, MODE_4: begin
                    if (load_q) begin
                        ce_d    = cr_q;
                        load_d  = 1'b0;
                        run_d   = 1'b1;
                        armed_d = 1'b1;
                    end else begin
                        // Strobe low lasts exactly one clk0 period.
                        if (mode_q == MODE_4 && !out_q) begin
                            out_d = 1'b1;
                        end
                        if (run_q && gate_q) begin
                            ce_d = dec1;
                            if (dec1 == 16'd0 && armed_q) begin
                                armed_d = 1'b0;
                                out_d   = (mode_q == MODE_0);
                            end
                        end
                    end
                end
                MODE_1, MODE_5: begin
                    if (gtrig_q && (load_q || started_q)) begin
                        ce_d      = cr_q;
                        load_d    = 1'b0;
                        run_d     = 1'b1;
                        started_d = 1'b1;
                        armed_d   = 1'b1;
                        out_d     = (mode_q != MODE_1);
                    end else begin
                        if (mode_q == MODE_5 && !out_q) begin
                            out_d = 1'b1;
                        end
                        // Gate level does not pause a one-shot.
                        if (run_q) begin
                            ce_d = dec1;
                            if (dec1 == 16'd0 && armed_q) begin
                                armed_d = 1'b0;
                                out_d   = (mode_q == MODE_1);
                            end
                        end
                    end
                end
                MODE_2: begin
                    if (load_q || (gtrig_q && run_q)) begin
                        ce_d   = cr_q;
                        load_d = 1'b0;
                        run_d  = 1'b1;
                        out_d  = 1'b1;
                    end else if (run_q && gate_q) begin
                        if (ce_q == 16'd1) begin
                            ce_d  = cr_q;
                            out_d = 1'b1;
                        end else begin
                            ce_d = dec1;
                            if (dec1 == 16'd1) begin
                                out_d = 1'b0;
                            end
                        end
                    end
                end
                MODE_3: begin
                    if (load_q || (gtrig_q && run_q)) begin
                        ce_d   = cr_even;
                        hold_d = cr_q[0];
                        load_d = 1'b0;
                        run_d  = 1'b1;
                        out_d  = 1'b1;
                    end else if (run_q && gate_q) begin
                        // Odd counts spend one extra period in the high half.
                        if (ce_q == 16'd2 && hold_q) begin
                            hold_d = 1'b0;
                        end else if (ce_q == 16'd2) begin
                            out_d  = ~out_q;
                            ce_d   = cr_even;
                            hold_d = cr_q[0] & ~out_q;
                        end else begin
                            ce_d = dec2;
                        end
                    end
                end
                default: begin
                    run_d = 1'b0;
                end
            endcase
        end

        if (rise_edge) begin
            gate_d = gate0;
            if (gate0 && !gate_q) begin
                gtrig_d = 1'b1;
            end
            if (!gate0 && (mode_q == MODE_2 || mode_q == MODE_3)) begin
                out_d = 1'b1;
            end
        end

        if (trig_rise) begin
            unique case (mode_q)
                MODE_0: begin
                    load_d = 1'b1;
                    run_d  = 1'b0;
                    out_d  = 1'b0;
                end
                MODE_4: begin
                    load_d = 1'b1;
                    run_d  = 1'b0;
                    out_d  = 1'b1;
                end
                MODE_1, MODE_5: begin
                    load_d = 1'b1;
                end
                MODE_2, MODE_3: begin
                    // A running divider picks the new CR up at its next reload.
                    if (!run_q) begin
                        load_d = 1'b1;
                    end
                end
                default: begin
                    load_d = 1'b0;
                end
            endcase
        end

        if (cw_rise) begin
            mode_d    = mode_sel;
            run_d     = 1'b0;
            load_d    = 1'b0;
            armed_d   = 1'b0;
            started_d = 1'b0;
            gtrig_d   = 1'b0;
            hold_d    = 1'b0;
            out_d     = (mode_sel != MODE_0);
`ifdef I8253_COUNTER_BCD_EN
            bcd_d     = bcd;
`endif
        end

        if (wr_lsb) begin
            cr_d[7:0] = load_counter;
        end
        if (wr_msb) begin
            cr_d[15:8] = load_counter;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_0;
            cr_q       <= 16'd0;
            ce_q       <= 16'd0;
            out_q      <= 1'b0;
            load_q     <= 1'b0;
            run_q      <= 1'b0;
            armed_q    <= 1'b0;
            started_q  <= 1'b0;
            gtrig_q    <= 1'b0;
            gate_q     <= 1'b0;
            hold_q     <= 1'b0;
            trig_dly_q <= 1'b0;
            cw_dly_q   <= 1'b0;
`ifdef I8253_COUNTER_BCD_EN
            bcd_q      <= 1'b0;
`endif
        end else begin
            mode_q     <= mode_d;
            cr_q       <= cr_d;
            ce_q       <= ce_d;
            out_q      <= out_d;
            load_q     <= load_d;
            run_q      <= run_d;
            armed_q    <= armed_d;
            started_q  <= started_d;
            gtrig_q    <= gtrig_d;
            gate_q     <= gate_d;
            hold_q     <= hold_d;
            trig_dly_q <= wr_trigger;
            cw_dly_q   <= wr_cw;
`ifdef I8253_COUNTER_BCD_EN
            bcd_q      <= bcd_d;
`endif
        end
    end

endmodule

// File: tb/tb_i8253_counter.sv
// tb_i8253_counter: directed-random bench for one 8253 counter channel.
// Expected OUT/CE values come from per-mode period arithmetic.

module tb_i8253_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk0_en;
    logic        clk0;
    logic        gate0;
    logic        out0;
    logic [7:0]  load_counter;
    logic [15:0] counter0;
    logic        wr_cw;
    logic        wr_lsb;
    logic        wr_msb;
    logic        wr_trigger;
    logic        mode0;
    logic        mode1;
    logic        mode2;
    logic        mode3;
    logic        mode4;
    logic        mode5;
    logic        bcd;

    int total = 0;
    int bad   = 0;

    i8253_counter dut (
        .clk          (clk),
        .reset        (reset),
        .clk0_en      (clk0_en),
        .clk0         (clk0),
        .gate0        (gate0),
        .out0         (out0),
        .load_counter (load_counter),
        .counter0     (counter0),
        .wr_cw        (wr_cw),
        .wr_lsb       (wr_lsb),
        .wr_msb       (wr_msb),
        .wr_trigger   (wr_trigger),
        .mode0        (mode0),
        .mode1        (mode1),
        .mode2        (mode2),
        .mode3        (mode3),
        .mode4        (mode4),
        .mode5        (mode5),
        .bcd          (bcd)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk0 period: rising edge, then falling (count) edge.
    task automatic period();
        clk0_en = 1'b1;
        tick();
        clk0    = 1'b1;
        clk0_en = 1'b0;
        tick();
        clk0_en = 1'b1;
        tick();
        clk0    = 1'b0;
        clk0_en = 1'b0;
        tick();
    endtask

    task automatic cw(input logic [5:0] m, input logic b);
        {mode5, mode4, mode3, mode2, mode1, mode0} = m;
        bcd   = b;
        wr_cw = 1'b1;
        tick();
        tick();
        wr_cw = 1'b0;
        {mode5, mode4, mode3, mode2, mode1, mode0} = 6'b0;
        tick();
    endtask

    task automatic wr_cr(input logic [15:0] v);
        load_counter = v[7:0];
        wr_lsb       = 1'b1;
        tick();
        tick();
        wr_lsb       = 1'b0;
        load_counter = v[15:8];
        wr_msb       = 1'b1;
        tick();
        wr_msb       = 1'b0;
        tick();
    endtask

    task automatic trig();
        wr_trigger = 1'b1;
        tick();
        tick();
        wr_trigger = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int m;
        int g;
        int e;
        int t;
        int len;
        int crv;
        int low;
        logic [15:0] x;

        reset        = 1'b1;
        clk0_en      = 1'b0;
        clk0         = 1'b0;
        gate0        = 1'b0;
        load_counter = 8'h00;
        wr_cw        = 1'b0;
        wr_lsb       = 1'b0;
        wr_msb       = 1'b0;
        wr_trigger   = 1'b0;
        {mode5, mode4, mode3, mode2, mode1, mode0} = 6'b0;
        bcd          = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("rst_count", 32'(counter0), 32'h0);
        chk("rst_out", 32'(out0), 32'h0);

        // Mode 0: load, count down to 0, OUT high and staying high.
        gate0 = 1'b1;
        period();
        cw(6'b000001, 1'b0);
        chk("m0_cw_out", 32'(out0), 32'h0);
        n = $urandom_range(3, 9);
        wr_cr(16'(n));
        trig();
        chk("m0_trig_out", 32'(out0), 32'h0);
        for (int k = 1; k <= n + 3; k++) begin
            period();
            x = 16'(n - (k - 1));
            chk("m0_count", 32'(counter0), 32'(x));
            chk("m0_out", 32'(out0), 32'(k >= n + 1));
        end

        // Mode 0 retrigger with a 4-period gate-low gap mid-count.
        n = $urandom_range(5, 9);
        g = $urandom_range(2, n - 1);
        wr_cr(16'(n));
        trig();
        chk("m0g_trig_out", 32'(out0), 32'h0);
        e = 0;
        for (int p = 1; p <= n + 7; p++) begin
            gate0 = (p >= g + 1 && p <= g + 4) ? 1'b0 : 1'b1;
            period();
            if (p > 1 && gate0) e++;
            x = 16'(n - e);
            chk("m0g_count", 32'(counter0), 32'(x));
            chk("m0g_out", 32'(out0), 32'(e >= n));
        end
        gate0 = 1'b1;

        // CR=0 counts as 65536: loads 0 then wraps to FFFF without OUT.
        wr_cr(16'h0000);
        trig();
        period();
        chk("m0z_load", 32'(counter0), 32'h0);
        period();
        chk("m0z_wrap", 32'(counter0), 32'hFFFF);
        chk("m0z_out", 32'(out0), 32'h0);

        // bcd=1: decade borrow and 0000 wrap when BCD is built in.
        cw(6'b000001, 1'b1);
        wr_cr(16'h0010);
        trig();
        period();
        chk("bcd_load", 32'(counter0), 32'h0010);
        period();
`ifdef I8253_COUNTER_BCD_EN
        x = 16'h0009;
`else
        x = 16'h000F;
`endif
        chk("bcd_borrow", 32'(counter0), 32'(x));
        wr_cr(16'h0001);
        trig();
        period();
        period();
        chk("bcd_zero", 32'(counter0), 32'h0);
        chk("bcd_zero_out", 32'(out0), 32'h1);
        period();
`ifdef I8253_COUNTER_BCD_EN
        x = 16'h9999;
`else
        x = 16'hFFFF;
`endif
        chk("bcd_wrap", 32'(counter0), 32'(x));

        // Mode 1: armed by trigger, fired by gate; low exactly N periods.
        gate0 = 1'b0;
        period();
        cw(6'b000010, 1'b0);
        chk("m1_cw_out", 32'(out0), 32'h1);
        n = $urandom_range(2, 8);
        wr_cr(16'(n));
        trig();
        period();
        period();
        chk("m1_armed_out", 32'(out0), 32'h1);
        for (int r = 0; r < 2; r++) begin
            low = 0;
            for (int p = 1; p <= 20; p++) begin
                gate0 = (p == 1);
                period();
                if (p == 1) begin
                    chk("m1_load", 32'(counter0), 32'(n));
                    chk("m1_first_low", 32'(out0), 32'h0);
                end
                if (out0 == 1'b0) low++;
            end
            chk("m1_low_len", 32'(low), 32'(n));
        end

        // Mode 2: one low period per cycle; new CR at next reload.
        gate0 = 1'b1;
        cw(6'b000100, 1'b0);
        chk("m2_cw_out", 32'(out0), 32'h1);
        n = $urandom_range(3, 8);
        m = $urandom_range(10, 20);
        wr_cr(16'(n));
        trig();
        crv = n;
        len = n;
        t   = 0;
        for (int p = 1; p <= 2 * n + 2 * m + 2; p++) begin
            period();
            if (p == 1 || t == len) begin
                t   = 1;
                len = crv;
            end else begin
                t++;
            end
            chk("m2_out", 32'(out0), 32'(t != len));
            if (p == 2 * n + 1) begin
                wr_cr(16'(m));
                trig();
                crv = m;
            end
        end

        // Mode 3: high ceil(N/2), low floor(N/2); gate low forces high.
        cw(6'b001000, 1'b0);
        chk("m3_cw_out", 32'(out0), 32'h1);
        n = $urandom_range(4, 9);
        wr_cr(16'(n));
        trig();
        for (int p = 1; p <= 3 * n; p++) begin
            period();
            chk("m3_out", 32'(out0), 32'(((p - 1) % n) < (n + 1) / 2));
        end
        gate0 = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            period();
            chk("m3_gate_low", 32'(out0), 32'h1);
        end
        gate0 = 1'b1;
        for (int p = 1; p <= 2 * n; p++) begin
            period();
            chk("m3_restart", 32'(out0), 32'(((p - 1) % n) < (n + 1) / 2));
        end

        // Mode 4 (mode4 and mode5 both flagged: mode4 must win).
        cw(6'b110000, 1'b0);
        chk("m4_cw_out", 32'(out0), 32'h1);
        n = $urandom_range(5, 40);
        wr_cr(16'(n));
        trig();
        chk("m4_trig_out", 32'(out0), 32'h1);
        for (int p = 1; p <= n + 4; p++) begin
            period();
            if (p == 1) chk("m4_load", 32'(counter0), 32'(n));
            chk("m4_out", 32'(out0), 32'(p != n + 1));
        end

        // Mode 5: gate rise starts and restarts a one-period strobe.
        gate0 = 1'b0;
        period();
        cw(6'b100000, 1'b0);
        chk("m5_cw_out", 32'(out0), 32'h1);
        n = $urandom_range(2, 8);
        wr_cr(16'(n));
        trig();
        period();
        period();
        chk("m5_armed_out", 32'(out0), 32'h1);
        for (int r = 0; r < 2; r++) begin
            gate0 = 1'b0;
            period();
            for (int p = 1; p <= n + 3; p++) begin
                gate0 = 1'b1;
                period();
                if (p == 1) chk("m5_load", 32'(counter0), 32'(n));
                chk("m5_out", 32'(out0), 32'(p != n + 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
